ring_stream_rand: RTL and testbench
===================================

RING_STREAM_RAND -- requirements
Module: ring_stream_rand

Interface
REQ-001 The block SHALL have parameter DATA_W, default 14, sample width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 7, address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port din  input  DATA_W  write data.
REQ-006 The block SHALL have port wr_en  input  1  append din at write pointer.
REQ-007 The block SHALL have port full  output  1  count == DEPTH; writes ignored.
REQ-008 The block SHALL have port count  output  ADDR_W+1  number of stored entries.
REQ-009 The block SHALL have port m_data  output  DATA_W  stream data.
REQ-010 The block SHALL have port m_index  output  ADDR_W  address of m_data.
REQ-011 The block SHALL have port m_valid  output  1  m_data/m_index valid.
REQ-012 The block SHALL have port m_ready  input  1  consumer accepts beat when m_valid & m_ready.
REQ-013 The block SHALL have port rand_rd_en  input  1  random read request, one-cycle pulse.
REQ-014 The block SHALL have port rand_rd_addr  input  ADDR_W  random read address.
REQ-015 The block SHALL have port rand_busy  output  1  random read in flight; new requests ignored.
REQ-016 The block SHALL have port rand_rd_data  output  DATA_W  random read result.
REQ-017 The block SHALL have port rand_rd_valid  output  1  one-cycle strobe qualifying rand_rd_data.
REQ-018 The block SHALL have port rand_rd_err  output  1  with rand_rd_valid: rand_rd_addr >= count, data forced to 0.

Function
REQ-019 Storage SHALL be an inferred simple dual-port RAM, DEPTH x DATA_W, one write and one read port, read latency 1 cycle.
REQ-020 Write accepted iff wr_en & ~full: RAM[count] <= din, count += 1 the same edge; wr_en while full SHALL be dropped without side effects.
REQ-021 Stream SHALL cycle addresses 0,1,...,count-1,0,... indefinitely while count > 0; m_valid SHALL be 0 while count == 0.
REQ-022 An accepted write SHALL flush the stream: prefetch buffer emptied, m_valid deasserted the next cycle, read pointer reset to 0, so the next beat is index 0 with the new count.
REQ-023 Stream path SHALL use a 2-entry prefetch buffer issuing RAM reads only when a slot is free, sustaining one beat per clock with m_ready held high.
REQ-024 m_data/m_index SHALL be held stable while m_valid & ~m_ready.
REQ-025 First m_valid after flush or reset SHALL occur no later than 3 cycles after count becomes nonzero.
REQ-026 rand_rd_en & ~rand_busy SHALL latch the address and set rand_busy; the RAM read port SHALL be granted to the random read in the next cycle at which it is free, stalling stream prefetch for that cycle only.
REQ-027 rand_rd_valid SHALL pulse exactly once per accepted request, 2 to 4 cycles after rand_rd_en; rand_busy SHALL clear the same cycle.
REQ-028 A random read SHALL NOT disturb stream order, index sequence or m_valid of beats already buffered.
REQ-029 An accepted write coinciding with a pending random read SHALL not cancel it; err SHALL be evaluated against count at issue.
REQ-030 rand_rd_en and wr_en in the same cycle SHALL both be accepted.

Reset
REQ-031 On rst: count=0, full=0, m_valid=0, m_data=0, m_index=0, rand_busy=0, rand_rd_valid=0, rand_rd_err=0, rand_rd_data=0, pointers=0; RAM contents need not be cleared.
REQ-032 rst mid-operation SHALL abort any pending random read with no rand_rd_valid strobe.

Configuration
REQ-033 Macro RING_RAND_ACCESS_EN: defined -> random read port per REQ-026..030; undefined -> rand_rd_en ignored, rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data tied 0, stream never stalls.

Verification
REQ-034 Reset, write 5 samples 10..14, m_ready=1 -> beats 10,11,12,13,14,10,11... with m_index 0..4,0.. and no bubbles after the first beat.
REQ-035 Stream running at index 3, write 99 -> flush; next beats index 0,1,..,5 ending with 99, count=6.
REQ-036 Write 128 samples (default parameters), then one more -> full=1, count=128, 129th sample dropped, stream wraps 127 -> 0.
REQ-037 count=5, m_ready toggling 1/0 each cycle, rand_rd_en addr 2 -> rand_rd_data=RAM[2] within 4 cycles, stream sequence gapless in index.
REQ-038 count=5, rand_rd_addr 7 -> rand_rd_valid=1, rand_rd_err=1, rand_rd_data=0; second request during rand_busy -> ignored.
REQ-039 Pending random read, assert rst -> no rand_rd_valid, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ring_stream_rand.sv
// ring_stream_rand
//   Ring buffer that is filled by appending samples and is read back as an
//   endless, cyclic stream (addresses 0..count-1, then 0 again). It also has
//   an optional random-access read port that borrows the single RAM read
//   port for one cycle.
//
//   Build option: define RING_RAND_ACCESS_EN to enable the random read port.
//   Without it, rand_rd_en/rand_rd_addr are ignored and every rand_* output
//   is tied to zero, so the stream prefetch never stalls.
//
// Ports
//   clk           : single clock, all logic on the rising edge
//   rst           : synchronous active-high reset
//   din, wr_en    : append din at address count when not full
//   full, count   : fill status (count ranges over 0..DEPTH)
//   m_data/m_index/m_valid/m_ready : stream output with valid/ready handshake
//   rand_rd_en, rand_rd_addr       : one-cycle random read request
//   rand_busy                      : random read in flight, new requests ignored
//   rand_rd_data/rand_rd_valid/rand_rd_err : random read result strobe
module ring_stream_rand #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              rand_rd_en,
  input  logic [ADDR_W-1:0] rand_rd_addr,
  output logic              rand_busy,
  output logic [DATA_W-1:0] rand_rd_data,
  output logic              rand_rd_valid,
  output logic              rand_rd_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DepthCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   OneCount   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] OnePtr     = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ramRdData_q;
  logic              ramRdEn;
  logic [ADDR_W-1:0] ramRdAddr;

  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] readPtr_q, readPtr_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflightIdx_q, inflightIdx_d;
  logic [DATA_W-1:0] buf0Data_q, buf0Data_d, buf1Data_q, buf1Data_d;
  logic [ADDR_W-1:0] buf0Idx_q, buf0Idx_d, buf1Idx_q, buf1Idx_d;

  logic              wrAccept;
  logic              pop;
  logic              streamIssue;
  logic              randGrant;
  logic [ADDR_W-1:0] randRdAddr;

  assign full     = (count_q == DepthCount);
  assign count    = count_q;
  assign wrAccept = wr_en & ~full;

  // Buffer slot 0 is always the head of the stream.
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0Data_q;
  assign m_index = buf0Idx_q;
  assign pop     = m_valid & m_ready;

  // A stream read is issued when, after this cycle's pop, a buffer slot will
  // still be free for the returning data. A random read owns the port for its
  // grant cycle, and an accepted write flushes, so neither cycle issues.
  assign streamIssue = ~wrAccept & ~randGrant & (count_q != '0) &
                       ((({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) | pop);

  assign ramRdEn   = randGrant | streamIssue;
  assign ramRdAddr = randGrant ? randRdAddr : readPtr_q;

  // Simple dual-port RAM: write at the fill position, registered read.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[count_q[ADDR_W-1:0]] <= din;
    end
    if (ramRdEn) begin
      ramRdData_q <= mem[ramRdAddr];
    end
  end

  // Stream next-state: a write flushes the buffer and the pending read;
  // otherwise returning read data is pushed behind the current head.
  always_comb begin
    count_d       = count_q;
    readPtr_d     = readPtr_q;
    occ_d         = occ_q;
    inflight_d    = inflight_q;
    inflightIdx_d = inflightIdx_q;
    buf0Data_d    = buf0Data_q;
    buf0Idx_d     = buf0Idx_q;
    buf1Data_d    = buf1Data_q;
    buf1Idx_d     = buf1Idx_q;

    if (wrAccept) begin
      count_d    = count_q + OneCount;
      readPtr_d  = '0;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = streamIssue;
      if (streamIssue) begin
        inflightIdx_d = readPtr_q;
        readPtr_d     = ({1'b0, readPtr_q} == (count_q - OneCount)) ? '0 : readPtr_q + OnePtr;
      end

      if (pop) begin
        buf0Data_d = buf1Data_q;
        buf0Idx_d  = buf1Idx_q;
      end

      // New data lands in slot 0 only if slot 0 is empty after the pop.
      if (inflight_q) begin
        if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
          buf0Data_d = ramRdData_q;
          buf0Idx_d  = inflightIdx_q;
        end else begin
          buf1Data_d = ramRdData_q;
          buf1Idx_d  = inflightIdx_q;
        end
      end

      occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // Stream state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      readPtr_q     <= '0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      inflightIdx_q <= '0;
      buf0Data_q    <= '0;
      buf0Idx_q     <= '0;
      buf1Data_q    <= '0;
      buf1Idx_q     <= '0;
    end else begin
      count_q       <= count_d;
      readPtr_q     <= readPtr_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      inflightIdx_q <= inflightIdx_d;
      buf0Data_q    <= buf0Data_d;
      buf0Idx_q     <= buf0Idx_d;
      buf1Data_q    <= buf1Data_d;
      buf1Idx_q     <= buf1Idx_d;
    end
  end

`ifdef RING_RAND_ACCESS_EN
  typedef enum logic [1:0] {
    RAND_IDLE,
    RAND_GRANT,
    RAND_DATA
  } randState_e;

  randState_e        randState_q, randState_d;
  logic [ADDR_W-1:0] randAddr_q, randAddr_d;
  logic              randErr_q, randErr_d;
  logic [DATA_W-1:0] randData_q, randData_d;
  logic              randValid_q, randValid_d;
  logic              randErrOut_q, randErrOut_d;

  // Random read sequencer: latch the request, take the RAM port in the next
  // cycle, then publish the result. The range check uses the count seen when
  // the request arrives, and out-of-range requests never touch the RAM.
  always_comb begin
    randState_d  = randState_q;
    randAddr_d   = randAddr_q;
    randErr_d    = randErr_q;
    randData_d   = randData_q;
    randValid_d  = 1'b0;
    randErrOut_d = 1'b0;
    randGrant    = 1'b0;

    case (randState_q)
      RAND_IDLE: begin
        if (rand_rd_en) begin
          randAddr_d  = rand_rd_addr;
          randErr_d   = ({1'b0, rand_rd_addr} >= count_q);
          randState_d = RAND_GRANT;
        end
      end
      RAND_GRANT: begin
        randGrant   = ~randErr_q;
        randState_d = RAND_DATA;
      end
      RAND_DATA: begin
        randValid_d  = 1'b1;
        randErrOut_d = randErr_q;
        randData_d   = randErr_q ? '0 : ramRdData_q;
        randState_d  = RAND_IDLE;
      end
      default: begin
        randState_d = RAND_IDLE;
      end
    endcase
  end

  // Random read registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      randState_q  <= RAND_IDLE;
      randAddr_q   <= '0;
      randErr_q    <= 1'b0;
      randData_q   <= '0;
      randValid_q  <= 1'b0;
      randErrOut_q <= 1'b0;
    end else begin
      randState_q  <= randState_d;
      randAddr_q   <= randAddr_d;
      randErr_q    <= randErr_d;
      randData_q   <= randData_d;
      randValid_q  <= randValid_d;
      randErrOut_q <= randErrOut_d;
    end
  end

  assign randRdAddr    = randAddr_q;
  assign rand_busy     = (randState_q != RAND_IDLE);
  assign rand_rd_data  = randData_q;
  assign rand_rd_valid = randValid_q;
  assign rand_rd_err   = randErrOut_q;
`else
  logic unusedRand;
  assign unusedRand    = rand_rd_en ^ (^rand_rd_addr);
  assign randGrant     = 1'b0;
  assign randRdAddr    = '0;
  assign rand_busy     = 1'b0;
  assign rand_rd_data  = '0;
  assign rand_rd_valid = 1'b0;
  assign rand_rd_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ring_stream_rand.sv
// Testbench for ring_stream_rand. The reference model keeps the stored
// samples in a queue, the next expected stream index as a plain integer, and
// the outstanding random read as an expected value plus an age counter.
module tb_ring_stream_rand;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int DMASK  = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              full;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_valid;
  logic              m_ready;
  logic              rand_rd_en;
  logic [ADDR_W-1:0] rand_rd_addr;
  logic              rand_busy;
  logic [DATA_W-1:0] rand_rd_data;
  logic              rand_rd_valid;
  logic              rand_rd_err;

  always #5 clk = ~clk;

  ring_stream_rand #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .full         (full),
    .count        (count),
    .m_data       (m_data),
    .m_index      (m_index),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .rand_rd_en   (rand_rd_en),
    .rand_rd_addr (rand_rd_addr),
    .rand_busy    (rand_busy),
    .rand_rd_data (rand_rd_data),
    .rand_rd_valid(rand_rd_valid),
    .rand_rd_err  (rand_rd_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  int mdl[$];
  int expIdx      = 0;
  bit randPend    = 0;
  int randAge     = 0;
  int randExpData = 0;
  bit randExpErr  = 0;

  // Synchronous reset pulse; leaves the bench at a falling edge.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; din = '0; m_ready = 1'b0;
    rand_rd_en = 1'b0; rand_rd_addr = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl.delete();
    expIdx = 0; randPend = 0; randAge = 0;
  endtask

  // Drive one cycle from a falling edge and advance the model across the
  // rising edge; returns at the next falling edge.
  task automatic applyStimulus(input bit w, input int d, input bit rdy, input bit re, input int ra);
    bit beatNow;
    wr_en = w; din = DATA_W'(d); m_ready = rdy;
    rand_rd_en = re; rand_rd_addr = ADDR_W'(ra);
    beatNow = m_valid && rdy;
    @(posedge clk);
`ifdef RING_RAND_ACCESS_EN
    if (randPend) randAge++;
    if (re && !randPend) begin
      randPend    = 1;
      randAge     = 1;
      randExpErr  = (ra >= mdl.size());
      randExpData = randExpErr ? 0 : mdl[ra];
    end
`endif
    if (beatNow && mdl.size() > 0) expIdx = (expIdx + 1) % mdl.size();
    if (w && mdl.size() < DEPTH) begin
      mdl.push_back(d & DMASK);
      expIdx = 0;
    end
    @(negedge clk);
    wr_en = 1'b0; rand_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    vectors++;
    if (count !== '0 || full !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_count: count %0d full %0d, expected 0 0", count, full);
    end
    vectors++;
    if ({m_valid, m_data, m_index} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_stream: valid %0d data %0d index %0d, expected all 0", m_valid, m_data, m_index);
    end
    vectors++;
    if ({rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_rand: busy %0d valid %0d err %0d data %0d, expected all 0",
                              rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data);
    end
  endtask

  task automatic test_stream_basic();
    int firstAt;
    bit bubble;
    firstAt = -1; bubble = 0;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 10 + i, 1, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      if (k == 1) begin
        vectors++;
        if (count !== (ADDR_W + 1)'(5) || m_valid !== 1'b0) begin
          miscompares++; $display("[TB] FAIL basic_flush: count %0d valid %0d, expected 5 0", count, m_valid);
        end
      end
      if (m_valid) begin
        vectors++;
        if (mdl.size() == 0 || m_index !== ADDR_W'(expIdx) || m_data !== DATA_W'(mdl[expIdx])) begin
          miscompares++; $display("[TB] FAIL basic_beat: index %0d data %0d, expected index %0d data %0d",
                                  m_index, m_data, expIdx, (mdl.size() > 0) ? mdl[expIdx] : -1);
        end
        if (firstAt < 0) firstAt = k;
      end else if (firstAt >= 0) begin
        bubble = 1;
      end
      applyStimulus(0, 0, 1, 0, 0);
    end
    vectors++;
    if (firstAt < 2 || firstAt > 4) begin
      miscompares++; $display("[TB] FAIL basic_latency: first beat in cycle %0d, expected 2..4", firstAt);
    end
    vectors++;
    if (bubble !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_bubble: gap %0d, expected 0", bubble);
    end
  endtask

  task automatic test_flush();
    bit found;
    bit sawLast;
    found = 0; sawLast = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_valid && m_index == ADDR_W'(3)) found = 1;
      else applyStimulus(0, 0, 1, 0, 0);
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_setup: index 3 seen %0d, expected 1", found);
    end
    applyStimulus(1, 99, 1, 0, 0);
    vectors++;
    if (m_valid !== 1'b0 || count !== (ADDR_W + 1)'(6)) begin
      miscompares++; $display("[TB] FAIL flush_state: valid %0d count %0d, expected 0 6", m_valid, count);
    end
    for (int k = 0; k < 12; k++) begin
      if (m_valid) begin
        vectors++;
        if (mdl.size() == 0 || m_index !== ADDR_W'(expIdx) || m_data !== DATA_W'(mdl[expIdx])) begin
          miscompares++; $display("[TB] FAIL flush_beat: index %0d data %0d, expected index %0d data %0d",
                                  m_index, m_data, expIdx, (mdl.size() > 0) ? mdl[expIdx] : -1);
        end
        if (m_index == ADDR_W'(5) && m_data == DATA_W'(99)) sawLast = 1;
      end
      applyStimulus(0, 0, 1, 0, 0);
    end
    vectors++;
    if (sawLast !== 1'b1) begin
      miscompares++; $display("[TB] FAIL flush_last: index 5 with 99 seen %0d, expected 1", sawLast);
    end
  endtask

  task automatic test_full_wrap();
    int prevIdx;
    bit sawWrap;
    prevIdx = -1; sawWrap = 0;
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        vectors++;
        if (full !== 1'b0 || count !== (ADDR_W + 1)'(DEPTH - 1)) begin
          miscompares++; $display("[TB] FAIL full_early: full %0d count %0d, expected 0 127", full, count);
        end
      end
      applyStimulus(1, int'($urandom_range(0, DMASK)), bit'($urandom_range(0, 1)), 0, 0);
    end
    vectors++;
    if (full !== 1'b1 || count !== (ADDR_W + 1)'(DEPTH)) begin
      miscompares++; $display("[TB] FAIL full_set: full %0d count %0d, expected 1 128", full, count);
    end
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 5555, 1, 0, 0);
    vectors++;
    if (full !== 1'b1 || count !== (ADDR_W + 1)'(DEPTH)) begin
      miscompares++; $display("[TB] FAIL full_drop: full %0d count %0d, expected 1 128", full, count);
    end
    for (int k = 0; k < 140; k++) begin
      if (m_valid) begin
        vectors++;
        if (mdl.size() == 0 || m_index !== ADDR_W'(expIdx) || m_data !== DATA_W'(mdl[expIdx])) begin
          miscompares++; $display("[TB] FAIL full_beat: index %0d data %0d, expected index %0d data %0d",
                                  m_index, m_data, expIdx, (mdl.size() > 0) ? mdl[expIdx] : -1);
        end
        if (prevIdx == DEPTH - 1 && m_index == '0) sawWrap = 1;
        prevIdx = int'(m_index);
      end
      applyStimulus(0, 0, 1, 0, 0);
    end
    vectors++;
    if (sawWrap !== 1'b1) begin
      miscompares++; $display("[TB] FAIL full_wrap: wrap 127->0 seen %0d, expected 1", sawWrap);
    end
  endtask

  task automatic test_random_mix();
    bit w, rdy, re;
    int ra;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, int'($urandom_range(0, DMASK)), 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      if (m_valid) begin
        vectors++;
        if (mdl.size() == 0 || m_index !== ADDR_W'(expIdx) || m_data !== DATA_W'(mdl[expIdx])) begin
          miscompares++; $display("[TB] FAIL mix_beat: index %0d data %0d, expected index %0d data %0d",
                                  m_index, m_data, expIdx, (mdl.size() > 0) ? mdl[expIdx] : -1);
        end
      end
      vectors++;
      if (count !== (ADDR_W + 1)'(mdl.size()) || full !== (mdl.size() == DEPTH)) begin
        miscompares++; $display("[TB] FAIL mix_count: count %0d full %0d, expected %0d %0d",
                                count, full, mdl.size(), mdl.size() == DEPTH);
      end
`ifdef RING_RAND_ACCESS_EN
      if (rand_rd_valid) begin
        vectors++;
        if (!randPend || randAge < 2 || randAge > 4 ||
            rand_rd_data !== DATA_W'(randExpData) || rand_rd_err !== randExpErr) begin
          miscompares++; $display("[TB] FAIL mix_rand: data %0d err %0d pending %0d age %0d, expected data %0d err %0d age 2..4",
                                  rand_rd_data, rand_rd_err, randPend, randAge, randExpData, randExpErr);
        end
        randPend = 0;
      end else if (randPend && randAge >= 4) begin
        vectors++; miscompares++;
        $display("[TB] FAIL mix_rand_timeout: no strobe after %0d cycles, expected within 4", randAge);
        randPend = 0;
      end
      vectors++;
      if (rand_busy !== randPend) begin
        miscompares++; $display("[TB] FAIL mix_busy: busy %0d, expected %0d", rand_busy, randPend);
      end
`else
      vectors++;
      if ({rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data} !== '0) begin
        miscompares++; $display("[TB] FAIL mix_rand_off: busy %0d valid %0d err %0d data %0d, expected all 0",
                                rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data);
      end
`endif
      w   = ($urandom_range(0, 24) == 0);
      rdy = (k < 150) ? k[0] : ($urandom_range(0, 3) != 0);
      re  = (k < 590) && ($urandom_range(0, 3) == 0);
      ra  = (k < 150) ? 2 : int'($urandom_range(0, mdl.size() + 3));
      if (ra > DEPTH - 1) ra = DEPTH - 1;
      applyStimulus(w, int'($urandom_range(0, DMASK)), rdy, re, ra);
    end
  endtask

`ifdef RING_RAND_ACCESS_EN
  task automatic test_rand_err();
    int pulses;
    int expData;
    pulses = 0;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 200 + i, 1, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 7);
    applyStimulus(0, 0, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      if (rand_rd_valid) begin
        pulses++;
        vectors++;
        if (rand_rd_err !== 1'b1 || rand_rd_data !== '0) begin
          miscompares++; $display("[TB] FAIL err_result: err %0d data %0d, expected 1 0", rand_rd_err, rand_rd_data);
        end
      end
      applyStimulus(0, 0, 1, 0, 0);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("[TB] FAIL err_pulses: %0d strobes, expected 1", pulses);
    end
    pulses = 0;
    expData = mdl[2];
    applyStimulus(1, 777, 1, 1, 2);
    vectors++;
    if (count !== (ADDR_W + 1)'(6)) begin
      miscompares++; $display("[TB] FAIL both_count: count %0d, expected 6", count);
    end
    for (int k = 0; k < 6; k++) begin
      if (rand_rd_valid) begin
        pulses++;
        vectors++;
        if (rand_rd_err !== 1'b0 || rand_rd_data !== DATA_W'(expData)) begin
          miscompares++; $display("[TB] FAIL both_result: err %0d data %0d, expected 0 %0d", rand_rd_err, rand_rd_data, expData);
        end
      end
      applyStimulus(0, 0, 1, 0, 0);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("[TB] FAIL both_pulses: %0d strobes, expected 1", pulses);
    end
  endtask

  task automatic test_rand_reset();
    int pulses;
    pulses = 0;
    applyStimulus(0, 0, 1, 1, 3);
    rst = 1'b1;
    applyStimulus(0, 0, 1, 0, 0);
    rst = 1'b0;
    mdl.delete();
    expIdx = 0; randPend = 0; randAge = 0;
    vectors++;
    if (count !== '0 || full !== 1'b0 || {m_valid, m_data, m_index} !== '0) begin
      miscompares++; $display("[TB] FAIL rst_stream: count %0d full %0d valid %0d data %0d index %0d, expected all 0",
                              count, full, m_valid, m_data, m_index);
    end
    vectors++;
    if ({rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data} !== '0) begin
      miscompares++; $display("[TB] FAIL rst_rand: busy %0d valid %0d err %0d data %0d, expected all 0",
                              rand_busy, rand_rd_valid, rand_rd_err, rand_rd_data);
    end
    for (int k = 0; k < 6; k++) begin
      if (rand_rd_valid) pulses++;
      applyStimulus(0, 0, 0, 0, 0);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++; $display("[TB] FAIL rst_abort: %0d strobes after reset, expected 0", pulses);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = '0; m_ready = 1'b0;
    rand_rd_en = 1'b0; rand_rd_addr = '0;
    $display("[TB] ring_stream_rand bench starting");
    test_reset();
    test_stream_basic();
    test_flush();
    test_full_wrap();
    test_random_mix();
`ifdef RING_RAND_ACCESS_EN
    test_rand_err();
    test_rand_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
